// File: rtl/mio_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mio_arbiter
//  Description : Round-robin arbiter sharing one fixed-latency RAM port
//                between the CPU MIO bus and a secondary (DMA) master.
//  Revision    : 1.0 - initial release
// ============================================================================
module mio_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2          // legal range 1..15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ready,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              dma_ready,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        owner,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_CPU  = 2'b01;
    localparam logic [1:0] OWN_DMA  = 2'b10;
    localparam logic [3:0] LAT_INIT = 4'(MEM_LAT);

    state_t              state_q, state_d;
    logic [1:0]          owner_q, owner_d;
    logic                last_dma_q, last_dma_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0]   dma_rdata_q, dma_rdata_d;
    logic                w_pick_dma;

    // DMA wins when it asks alone, or on a tie when the CPU was served last.
    assign w_pick_dma = dma_req & (~cpu_req | ~last_dma_q);

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_dma_d  = last_dma_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cnt_d       = cnt_q;
        cpu_rdata_d = cpu_rdata_q;
        dma_rdata_d = dma_rdata_q;
        case (state_q)
            S_IDLE: begin
                if (cpu_req | dma_req) begin
                    state_d = S_ISSUE;
                    if (w_pick_dma) begin
                        owner_d = OWN_DMA;
                        we_d    = dma_we;
                        addr_d  = dma_addr;
                        wdata_d = dma_wdata;
                    end else begin
                        owner_d = OWN_CPU;
                        we_d    = cpu_we;
                        addr_d  = cpu_addr;
                        wdata_d = cpu_wdata;
                    end
                end
            end
            S_ISSUE: begin
                cnt_d   = LAT_INIT;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q == 4'd1) begin
                    if (owner_q == OWN_DMA) begin
                        dma_rdata_d = mem_rdata;
                    end else begin
                        cpu_rdata_d = mem_rdata;
                    end
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_DONE: begin
                last_dma_d = (owner_q == OWN_DMA);
                owner_d    = OWN_NONE;
                state_d    = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                owner_d = OWN_NONE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            owner_q     <= OWN_NONE;
            last_dma_q  <= 1'b1;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cnt_q       <= '0;
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_dma_q  <= last_dma_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
            cpu_rdata_q <= cpu_rdata_d;
            dma_rdata_q <= dma_rdata_d;
        end
    end

    assign mem_en    = (state_q == S_ISSUE);
    assign mem_we    = mem_en & we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign cpu_ready = (state_q == S_DONE) && (owner_q == OWN_CPU);
    assign dma_ready = (state_q == S_DONE) && (owner_q == OWN_DMA);
    assign cpu_rdata = cpu_rdata_q;
    assign dma_rdata = dma_rdata_q;
    assign owner     = owner_q;
    assign busy      = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mio_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mio_arbiter
//  Description : Scoreboard bench for mio_arbiter (MEM_LAT 2, plus 1 and 15).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mio_arbiter;
    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cpu_req = 1'b0, cpu_we = 1'b0, dma_req = 1'b0, dma_we = 1'b0;
    logic [31:0] cpu_addr = '0, cpu_wdata = '0, dma_addr = '0, dma_wdata = '0;
    logic [31:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        cpu_ready, dma_ready, mem_en, mem_we, busy;
    logic [1:0]  owner;

    // short-latency and long-latency builds, CPU side only
    logic        a1_req = 1'b0, a15_req = 1'b0;
    logic [31:0] a1_rdata, a15_rdata, a1_drd, a15_drd, a1_ma, a15_ma, a1_mw, a15_mw, aux_mrd;
    logic        a1_rdy, a15_rdy, a1_drdy, a15_drdy, a1_en, a15_en, a1_we, a15_we, a1_busy, a15_busy;
    logic [1:0]  a1_own, a15_own;

    int cyc = 0;
    int total = 0;
    int bad = 0;

    typedef struct { bit dma; int cyc; logic [31:0] rdata; logic [31:0] other; } rdy_t;
    typedef struct { int cyc; bit we; logic [31:0] addr; logic [31:0] wdata; logic [1:0] own; } mem_t;
    rdy_t rdy_q[$];
    rdy_t a1_q[$];
    rdy_t a15_q[$];
    mem_t mem_q[$];
    rdy_t rr, ra1, ra15;
    mem_t mm;

    logic [31:0] ram [0:1023];
    logic [31:0] rd_word = 32'h0;
    int          rd_cyc = -100;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mio_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_rdata(dma_rdata), .dma_ready(dma_ready),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .owner(owner), .busy(busy)
    );

    mio_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) dut_l1 (
        .clk(clk), .reset(reset),
        .cpu_req(a1_req), .cpu_we(1'b0), .cpu_addr(32'h0), .cpu_wdata(32'h0),
        .cpu_rdata(a1_rdata), .cpu_ready(a1_rdy),
        .dma_req(1'b0), .dma_we(1'b0), .dma_addr(32'h0), .dma_wdata(32'h0),
        .dma_rdata(a1_drd), .dma_ready(a1_drdy),
        .mem_en(a1_en), .mem_we(a1_we), .mem_addr(a1_ma), .mem_wdata(a1_mw),
        .mem_rdata(aux_mrd), .owner(a1_own), .busy(a1_busy)
    );

    mio_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(15)) dut_l15 (
        .clk(clk), .reset(reset),
        .cpu_req(a15_req), .cpu_we(1'b0), .cpu_addr(32'h0), .cpu_wdata(32'h0),
        .cpu_rdata(a15_rdata), .cpu_ready(a15_rdy),
        .dma_req(1'b0), .dma_we(1'b0), .dma_addr(32'h0), .dma_wdata(32'h0),
        .dma_rdata(a15_drd), .dma_ready(a15_drdy),
        .mem_en(a15_en), .mem_we(a15_we), .mem_addr(a15_ma), .mem_wdata(a15_mw),
        .mem_rdata(aux_mrd), .owner(a15_own), .busy(a15_busy)
    );

    // RAM data is only valid in the exact capture cycle; poison otherwise.
    assign mem_rdata = (cyc == rd_cyc + LAT) ? rd_word : 32'hBAD0_BAD0;
    assign aux_mrd   = {16'hA000, cyc[15:0]};

    always @(negedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr[11:2]] = mem_wdata;
            rd_word = ram[mem_addr[11:2]];
            rd_cyc  = cyc;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic unexpected(input string nm);
        total++;
        bad++;
        $display("FAIL %s: got event expected none (cycle %0d)", nm, cyc);
    endtask

    task automatic to_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic push_mem(input int c, input bit we, input logic [31:0] a,
                            input logic [31:0] d, input logic [1:0] own);
        mem_t m;
        m.cyc = c; m.we = we; m.addr = a; m.wdata = d; m.own = own;
        mem_q.push_back(m);
    endtask

    task automatic push_rdy(input bit dma, input int c, input logic [31:0] rd, input logic [31:0] oth);
        rdy_t r;
        r.dma = dma; r.cyc = c; r.rdata = rd; r.other = oth;
        rdy_q.push_back(r);
    endtask

    // Monitors: compare whatever the DUTs present against the queued expectations.
    always @(negedge clk) begin
        if (mem_en) begin
            if (mem_q.size() == 0) unexpected("extra mem_en");
            else begin
                mm = mem_q.pop_front();
                chk("mem_en cycle", 64'(cyc), 64'(mm.cyc));
                chk("mem_we", 64'(mem_we), 64'(mm.we));
                chk("mem_addr", 64'(mem_addr), 64'(mm.addr));
                if (mm.we) chk("mem_wdata", 64'(mem_wdata), 64'(mm.wdata));
                chk("owner at issue", 64'(owner), 64'(mm.own));
                chk("busy at issue", 64'(busy), 64'd1);
            end
        end
        if (cpu_ready || dma_ready) begin
            if (rdy_q.size() == 0) unexpected("extra ready");
            else begin
                rr = rdy_q.pop_front();
                chk("ready exclusive", 64'(cpu_ready & dma_ready), 64'd0);
                chk("ready is dma", 64'(dma_ready), 64'(rr.dma));
                chk("ready cycle", 64'(cyc), 64'(rr.cyc));
                chk("winner rdata", 64'(rr.dma ? dma_rdata : cpu_rdata), 64'(rr.rdata));
                chk("other rdata", 64'(rr.dma ? cpu_rdata : dma_rdata), 64'(rr.other));
            end
        end
        if (a1_rdy) begin
            if (a1_q.size() == 0) unexpected("extra ready lat1");
            else begin
                ra1 = a1_q.pop_front();
                chk("lat1 ready cycle", 64'(cyc), 64'(ra1.cyc));
                chk("lat1 rdata", 64'(a1_rdata), 64'(ra1.rdata));
            end
        end
        if (a15_rdy) begin
            if (a15_q.size() == 0) unexpected("extra ready lat15");
            else begin
                ra15 = a15_q.pop_front();
                chk("lat15 ready cycle", 64'(cyc), 64'(ra15.cyc));
                chk("lat15 rdata", 64'(a15_rdata), 64'(ra15.rdata));
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // Latency builds: request sampled at cycle 5, capture at 6+L, ready at 7+L.
    initial begin
        rdy_t r;
        to_cyc(5);
        a1_req = 1'b1; a15_req = 1'b1;
        r.dma = 1'b0; r.other = '0;
        r.cyc = 8;  r.rdata = 32'hA000_0007; a1_q.push_back(r);
        r.cyc = 22; r.rdata = 32'hA000_0015; a15_q.push_back(r);
        to_cyc(6);
        a1_req = 1'b0; a15_req = 1'b0;
    end

    initial begin
        ram[64]  = 32'hDEAD_BEEF;   // 0x100
        ram[128] = 32'hCAFE_F00D;   // 0x200
        ram[16]  = 32'h0;           // 0x40

        to_cyc(1);
        chk("rst cpu_rdata", 64'(cpu_rdata), 64'd0);
        chk("rst dma_rdata", 64'(dma_rdata), 64'd0);
        chk("rst cpu_ready", 64'(cpu_ready), 64'd0);
        chk("rst dma_ready", 64'(dma_ready), 64'd0);
        chk("rst mem_en", 64'(mem_en), 64'd0);
        chk("rst mem_we", 64'(mem_we), 64'd0);
        chk("rst mem_addr", 64'(mem_addr), 64'd0);
        chk("rst mem_wdata", 64'(mem_wdata), 64'd0);
        chk("rst owner", 64'(owner), 64'd0);
        chk("rst busy", 64'(busy), 64'd0);
        to_cyc(3);
        reset = 1'b1;

        // CPU read of 0x100; fields scrambled mid-flight must be ignored
        to_cyc(5);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h100; cpu_wdata = 32'h55;
        push_mem(6, 1'b0, 32'h100, 32'h0, 2'b01);
        push_rdy(1'b0, 9, 32'hDEAD_BEEF, 32'h0);
        to_cyc(7);
        cpu_addr = 32'h200; cpu_we = 1'b1;
        to_cyc(9);
        cpu_req = 1'b0; cpu_we = 1'b0;

        // DMA write of 0x12345678 to 0x40
        to_cyc(15);
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h40; dma_wdata = 32'h1234_5678;
        push_mem(16, 1'b1, 32'h40, 32'h1234_5678, 2'b10);
        push_rdy(1'b1, 19, 32'h1234_5678, 32'hDEAD_BEEF);
        to_cyc(19);
        dma_req = 1'b0; dma_we = 1'b0;

        // CPU read with req dropped during ISSUE
        to_cyc(25);
        cpu_req = 1'b1; cpu_addr = 32'h200;
        push_mem(26, 1'b0, 32'h200, 32'h0, 2'b01);
        push_rdy(1'b0, 29, 32'hCAFE_F00D, 32'h1234_5678);
        to_cyc(26);
        cpu_req = 1'b0;

        // reset during WAIT abandons the transaction without a ready pulse
        to_cyc(35);
        cpu_req = 1'b1; cpu_addr = 32'h100;
        push_mem(36, 1'b0, 32'h100, 32'h0, 2'b01);
        to_cyc(36);
        cpu_req = 1'b0;
        to_cyc(37);
        reset = 1'b0;
        #1;
        chk("midrst mem_en", 64'(mem_en), 64'd0);
        chk("midrst busy", 64'(busy), 64'd0);
        chk("midrst owner", 64'(owner), 64'd0);
        chk("midrst cpu_rdata", 64'(cpu_rdata), 64'd0);
        chk("midrst dma_rdata", 64'(dma_rdata), 64'd0);
        to_cyc(39);
        reset = 1'b1;

        // tie with both requests held: CPU, DMA, CPU, DMA
        to_cyc(45);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h100;
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h200;
        push_mem(46, 1'b0, 32'h100, 32'h0, 2'b01);
        push_rdy(1'b0, 49, 32'hDEAD_BEEF, 32'h0);
        push_mem(51, 1'b0, 32'h200, 32'h0, 2'b10);
        push_rdy(1'b1, 54, 32'hCAFE_F00D, 32'hDEAD_BEEF);
        push_mem(56, 1'b0, 32'h100, 32'h0, 2'b01);
        push_rdy(1'b0, 59, 32'hDEAD_BEEF, 32'hCAFE_F00D);
        push_mem(61, 1'b0, 32'h200, 32'h0, 2'b10);
        push_rdy(1'b1, 64, 32'hCAFE_F00D, 32'hDEAD_BEEF);
        to_cyc(64);
        cpu_req = 1'b0; dma_req = 1'b0;

        to_cyc(75);
        chk("pending ready", 64'(rdy_q.size()), 64'd0);
        chk("pending mem_en", 64'(mem_q.size()), 64'd0);
        chk("pending lat1", 64'(a1_q.size()), 64'd0);
        chk("pending lat15", 64'(a15_q.size()), 64'd0);
        chk("idle busy", 64'(busy), 64'd0);
        chk("idle owner", 64'(owner), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mio_arbiter.md
# mio_arbiter

Shared memory-port arbiter between the multi-cycle CPU's MIO bus and a secondary bus master (DMA/display fetch). Accepts one transaction at a time from either requester, drives the single RAM port, waits a fixed memory latency, returns read data and a one-cycle ready pulse to the winner. The CPU-side ready output feeds the CPU's `MIO_ready` input; arbitration is round-robin, so neither master starves.

## Interface
- `ADDR_W`, 32, address width, both masters and RAM
- `DATA_W`, 32, data width
- `MEM_LAT`, 2, cycles from `mem_en` cycle to `mem_rdata` valid; legal range 1..15

- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-low; clears all state
- `cpu_req`  in  1  CPU transaction request (CPU_MIO), level
- `cpu_we`  in  1  1 = write, 0 = read
- `cpu_addr`  in  ADDR_W  CPU address
- `cpu_wdata`  in  DATA_W  CPU write data
- `cpu_rdata`  out  DATA_W  read data to CPU
- `cpu_ready`  out  1  one-cycle completion pulse to CPU
- `dma_req`, `dma_we`, `dma_addr`, `dma_wdata`  in  1/1/ADDR_W/DATA_W  same meaning for the DMA master
- `dma_rdata`  out  DATA_W; `dma_ready`  out  1  same meaning for the DMA master
- `mem_en`  out  1  RAM access strobe, one cycle per transaction
- `mem_we`  out  1  RAM write enable, valid only while `mem_en`=1
- `mem_addr`  out  ADDR_W; `mem_wdata`  out  DATA_W  RAM address and write data
- `mem_rdata`  in  DATA_W  RAM read data
- `owner`  out  2  00 none, 01 CPU, 10 DMA
- `busy`  out  1  high in every state except IDLE

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE: sample `cpu_req`/`dma_req`. If either is high, latch the winner's we/addr/wdata, set `owner`, go to ISSUE. Otherwise stay in IDLE.
- Arbitration with a single request: that requester wins.
- Arbitration with both requests: the requester not served last wins. The `last` register resets to DMA, so the CPU wins the first tie.
- ISSUE (one cycle):
  - `mem_en`=1, with `mem_we`/`mem_addr`/`mem_wdata` driven from the latched registers.
  - Load the latency counter with `MEM_LAT`, go to WAIT.
- WAIT:
  - Counter decrements each cycle.
  - In the cycle the counter reaches 1, `mem_rdata` is valid. Register it into the owner's rdata register; the other requester's rdata is unchanged. Writes perform the same capture, which is harmless.
  - Then go to DONE.
- DONE (one cycle):
  - Owner's ready = 1 and `last` := owner.
  - Next state IDLE; `owner` becomes 00 on entering IDLE.
- `cpu_rdata`/`dma_rdata` hold their value until that requester's next completed transaction.
- Requester inputs are sampled only in IDLE. Deasserting req or changing fields after IDLE has no effect: the transaction completes and ready still pulses.
- A requester still holding req during the IDLE cycle after DONE has issued a new transaction, subject to arbitration. Masters must drop req in the cycle after ready unless they intend a new access.
- `mem_we`, `mem_addr` and `mem_wdata` are don't-care when `mem_en`=0.
- Reset asserted mid-transaction:
  - State goes to IDLE immediately (async) and `mem_en` drops.
  - The in-flight transaction is abandoned with no ready pulse.
  - rdata registers are cleared and `last` is set to DMA.

## Timing
- Reset values: every output is 0, including both rdata, both ready, `mem_*`, `owner`=00 and `busy`=0.
- Request sampled in cycle t (IDLE):
  - `mem_en` is high in cycle t+1.
  - `mem_rdata` is sampled at the end of cycle t+1+MEM_LAT.
  - Ready and valid rdata appear in cycle t+2+MEM_LAT.
- Request-to-ready latency is MEM_LAT+2 cycles for both reads and writes.
- Minimum spacing between successive `mem_en` pulses is MEM_LAT+3 cycles.
- `busy` is high from cycle t+1 through the DONE cycle inclusive.
- No combinational path from any req input to any output; all outputs are registered or decoded from state.

## Test plan
- Single CPU read, MEM_LAT=2: RAM model returns 0xDEADBEEF for addr 0x100; `cpu_req` rises at cycle 5 → `mem_en`=1 at cycle 6 with addr 0x100 and `mem_we`=0; `cpu_ready`=1 with `cpu_rdata`=0xDEADBEEF at cycle 9 only; `dma_ready` stays 0.
- DMA write: `dma_req`/`dma_we`, addr 0x40, data 0x12345678 → one `mem_en` with `mem_we`=1 at that addr/data; `dma_ready` pulses MEM_LAT+2 cycles after the request cycle; `cpu_rdata` is unchanged.
- Tie after reset, both requests held continuously: grants go CPU, DMA, CPU, DMA; `owner` sequence is 01, 10, 01, 10; exactly one ready pulse per grant.
- Request dropped mid-flight: CPU read, `cpu_req` deasserted in ISSUE → `cpu_ready` still pulses at t+2+MEM_LAT and no extra `mem_en` follows.
- Reset mid-op: `reset` pulled low during WAIT → `mem_en`, `busy` and `owner` are 0 immediately; no ready pulse; after release, first tie goes to the CPU.
- MEM_LAT=1 and MEM_LAT=15 builds: request-to-ready latency is exactly 3 and 17 cycles respectively.
